// File: rtl/ariane_pkg.sv
// Shared types for the branch-history-table update generator: resolved-branch
// input, predictor training update, queue entry and drain FSM encoding.
package ariane_pkg;

  localparam int unsigned VLEN           = 64;
  localparam int unsigned BHT_UPD_STAT_W = 32;

  typedef enum logic [2:0] {
    NoCF   = 3'd0,
    Branch = 3'd1,
    Jump   = 3'd2,
    JumpR  = 3'd3,
    Return = 3'd4
  } cf_t;

  typedef struct packed {
    logic            valid;
    logic [VLEN-1:0] pc;
    logic            is_taken;
    logic            is_mispredict;
    cf_t             cf_type;
  } bp_resolve_t;

  typedef struct packed {
    logic            valid;
    logic [VLEN-1:0] pc;
    logic            taken;
    logic            mispredict;
  } bht_update_t;

  typedef struct packed {
    logic [VLEN-1:0] pc;
    logic            taken;
    logic            mispredict;
  } bht_upd_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } drain_state_e;

  function automatic bht_update_t to_update(input bht_upd_entry_t e);
    bht_update_t u;
    u.valid      = 1'b1;
    u.pc         = e.pc;
    u.taken      = e.taken;
    u.mispredict = e.mispredict;
    return u;
  endfunction

endpackage

// File: rtl/bht_upd_fifo.sv
// Circular queue of pending BHT updates. Pointers carry one extra wrap bit so
// full and empty are distinguished by comparing the MSBs.
module bht_upd_fifo
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   replace_youngest_i,
  input  bht_upd_entry_t         data_i,
  output bht_upd_entry_t         data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH) + 1;
  localparam int unsigned IDX_W = PTR_W - 1;

  bht_upd_entry_t   r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [IDX_W-1:0] w_wr_idx;
  logic [IDX_W-1:0] w_rd_idx;
  logic [IDX_W-1:0] w_young_idx;

  assign w_wr_idx    = r_wr_ptr[IDX_W-1:0];
  assign w_rd_idx    = r_rd_ptr[IDX_W-1:0];
  assign w_young_idx = w_wr_idx - IDX_W'(1);

  assign empty_o = (r_wr_ptr == r_rd_ptr);
  assign full_o  = (r_wr_ptr[IDX_W] != r_rd_ptr[IDX_W]) && (w_wr_idx == w_rd_idx);
  assign count_o = r_wr_ptr - r_rd_ptr;
  assign data_o  = r_mem[w_rd_idx];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push_i) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (pop_i)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone say which slots
  // hold live data, so resetting the array would only cost reset routing.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      r_mem[w_wr_idx] <= data_i;
    end else if (replace_youngest_i) begin
      r_mem[w_young_idx] <= data_i;
    end
  end

endmodule

// File: rtl/bht_update_gen.sv
// Queues resolved conditional branches and issues one registered BHT training
// update per cycle. Define BHT_UPD_STATS_EN to build the saturating counters.
module bht_update_gen
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned STAT_W = BHT_UPD_STAT_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              debug_mode_i,
  input  bp_resolve_t       resolved_branch_i,
  output bht_update_t       bht_update_o,
  output logic              full_o,
  output logic [STAT_W-1:0] stat_upd_o,
  output logic [STAT_W-1:0] stat_mis_o,
  output logic [STAT_W-1:0] stat_drop_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  drain_state_e   r_state;
  bht_update_t    r_upd;

  bht_upd_entry_t w_new_entry;
  bht_upd_entry_t w_head;
  bht_upd_entry_t w_issue_entry;
  logic           w_push_ok;
  logic           w_can_issue;
  logic           w_pop;
  logic           w_bypass;
  logic           w_issue;
  logic           w_fifo_push;
  logic           w_replace;
  logic           w_fifo_full;
  logic           w_fifo_empty;
  logic           w_occupied_nxt;
  logic [CNT_W-1:0] w_fifo_cnt;

  assign w_new_entry = '{pc:         resolved_branch_i.pc,
                         taken:      resolved_branch_i.is_taken,
                         mispredict: resolved_branch_i.is_mispredict};

  assign w_push_ok = resolved_branch_i.valid && (resolved_branch_i.cf_type == Branch) &&
                     !debug_mode_i && !flush_i;

  // The cycle debug drops the FSM is still in HOLD: pushes land, nothing pops.
  assign w_can_issue = (r_state != ST_HOLD) && !debug_mode_i && !flush_i;
  assign w_pop       = w_can_issue && !w_fifo_empty;
  assign w_bypass    = w_can_issue && w_fifo_empty && w_push_ok;
  assign w_issue     = w_pop || w_bypass;
  assign w_issue_entry = w_pop ? w_head : w_new_entry;

  // A full queue that cannot pop keeps only mispredicts, overwriting the youngest.
  assign w_fifo_push = w_push_ok && !w_bypass && (!w_fifo_full || w_pop);
  assign w_replace   = w_push_ok && w_fifo_full && !w_pop && w_new_entry.mispredict;

  assign w_occupied_nxt = w_fifo_push || (w_fifo_cnt > CNT_W'(w_pop));

  bht_upd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .flush_i            (flush_i),
    .push_i             (w_fifo_push),
    .pop_i              (w_pop),
    .replace_youngest_i (w_replace),
    .data_i             (w_new_entry),
    .data_o             (w_head),
    .full_o             (w_fifo_full),
    .empty_o            (w_fifo_empty),
    .count_o            (w_fifo_cnt)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_upd   <= '0;
    end else if (flush_i) begin
      r_state <= ST_IDLE;
      r_upd   <= '0;
    end else begin
      r_upd <= w_issue ? to_update(w_issue_entry) : '0;
      case (r_state)
        ST_IDLE, ST_DRAIN, ST_HOLD: begin
          if (debug_mode_i)        r_state <= ST_HOLD;
          else if (w_occupied_nxt) r_state <= ST_DRAIN;
          else                     r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bht_update_o = r_upd;
  assign full_o       = w_fifo_full;

`ifdef BHT_UPD_STATS_EN
  logic [STAT_W-1:0] r_stat_upd;
  logic [STAT_W-1:0] r_stat_mis;
  logic [STAT_W-1:0] r_stat_drop;
  logic              w_drop;

  assign w_drop = w_push_ok && w_fifo_full && !w_pop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stat_upd  <= '0;
      r_stat_mis  <= '0;
      r_stat_drop <= '0;
    end else begin
      if (w_issue && (r_stat_upd != '1))
        r_stat_upd <= r_stat_upd + STAT_W'(1);
      if (w_issue && w_issue_entry.mispredict && (r_stat_mis != '1))
        r_stat_mis <= r_stat_mis + STAT_W'(1);
      if (w_drop && (r_stat_drop != '1))
        r_stat_drop <= r_stat_drop + STAT_W'(1);
    end
  end

  assign stat_upd_o  = r_stat_upd;
  assign stat_mis_o  = r_stat_mis;
  assign stat_drop_o = r_stat_drop;
`else
  assign stat_upd_o  = '0;
  assign stat_mis_o  = '0;
  assign stat_drop_o = '0;
`endif

endmodule

// File: doc/bht_update_gen.md
BHT_UPDATE_GEN -- requirements
Module: bht_update_gen

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; power of two, 2..16.
REQ-002 Parameter STAT_W, default 32, statistics counter width.
REQ-003 Port clk_i  input  1  single clock, rising edge.
REQ-004 Port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 Port flush_i  input  1  synchronous queue clear.
REQ-006 Port debug_mode_i  input  1  core in debug mode.
REQ-007 Port resolved_branch_i  input  ariane_pkg::bp_resolve_t  resolved control flow (valid, pc, is_taken, is_mispredict, cf_type).
REQ-008 Port bht_update_o  output  ariane_pkg::bht_update_t  one predictor training update (valid, pc, taken, mispredict).
REQ-009 Port full_o  output  1  queue holds DEPTH entries.
REQ-010 Ports stat_upd_o, stat_mis_o, stat_drop_o  output  STAT_W each  issued updates, issued mispredicts, dropped entries.

Function
REQ-011 Push only when resolved_branch_i.valid, cf_type == ariane_pkg::Branch, debug_mode_i low and flush_i low; other cf_types are ignored.
REQ-012 Queued entry = {pc, is_taken, is_mispredict}; entries drain in strict arrival order.
REQ-013 bht_update_o is registered; an entry pushed in cycle N appears on bht_update_o no earlier than cycle N+1.
REQ-014 At most one update per cycle; bht_update_o.valid is high for exactly one cycle per entry (the consumer has no backpressure).
REQ-015 Drain FSM states: IDLE (queue empty), DRAIN (pop one entry per cycle), HOLD (debug_mode_i high, no pops).
REQ-016 Transitions: IDLE->DRAIN on non-empty; DRAIN->IDLE when last entry pops; any->HOLD on debug_mode_i; HOLD->IDLE or DRAIN on debug_mode_i low, according to occupancy.
REQ-017 In HOLD, bht_update_o.valid is 0, queue contents are preserved, and pushes are discarded without counting as drops.
REQ-018 A push and a pop in the same cycle are both honoured; occupancy is unchanged, including when full.
REQ-019 Overflow (full, no pop, push): a non-mispredict push is dropped and stat_drop_o increments.
REQ-020 Overflow with a mispredict push: the youngest stored entry is replaced by the new entry, and stat_drop_o increments.
REQ-021 Read and write pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full/empty are derived from the MSB comparison.
REQ-022 flush_i empties the queue the following cycle, drives bht_update_o.valid to 0, returns the FSM to IDLE, and leaves counters unchanged; a same-cycle push is discarded.
REQ-023 Counters saturate at 2^STAT_W-1.

Reset
REQ-024 On rst_ni low: queue empty, FSM IDLE, bht_update_o all zero, full_o 0, all counters 0; this takes effect immediately and also applies mid-drain.

Configuration
REQ-025 Macro BHT_UPD_STATS_EN defined: counters implemented per REQ-010/REQ-023.
REQ-026 Macro BHT_UPD_STATS_EN undefined: no counter flops; stat_* outputs tied to 0; all other behaviour is identical.

Structure
REQ-027 The queue entry typedef bht_upd_entry_t and the STAT_W default belong in ariane_pkg.
REQ-028 The storage is a sub-module bht_upd_fifo (push, pop, replace_youngest, full, empty, flush); the FSM and counters live in bht_update_gen.

Verification
REQ-029 Single push: Branch, pc=0x80, taken=1, mispredict=0 at cycle 5 -> bht_update_o={1,0x80,1,0} at cycle 6 only; stat_upd_o=1.
REQ-030 Burst: DEPTH=4, 4 pushes in consecutive cycles with no pops possible -> 4 updates in order on consecutive cycles; full_o never asserted.
REQ-031 Overflow: debug HOLD with 4 entries queued, debug drops, 5th non-mispredict push in the same cycle as the first pop -> all 5 delivered; repeat with no pop -> stat_drop_o=1, the 5th entry is never output.
REQ-032 Mispredict overflow: full queue, mispredict push pc=0x200 -> the 4th output is pc=0x200 with mispredict=1; stat_drop_o=1; stat_mis_o=1.
REQ-033 Debug: 2 entries queued, debug_mode_i high 3 cycles with a push -> no output during those cycles, push discarded, then 2 updates on consecutive cycles.
REQ-034 Flush and reset: flush_i with 3 entries queued -> no further updates; rst_ni low mid-drain -> outputs zero immediately.
